// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the single-cycle MIPS core: streams the program
// image into imem, holds the core in reset, runs it and reports status.
//
// Ports:
//   clk, reset (async, active-low)   clock and controller reset
//   start                            begin a run (honoured in IDLE/DONE)
//   ld_valid/ld_data/ld_last         image stream in, ld_ready back
//   imem_we/imem_addr/imem_wdata     imem write port
//   cpu_reset                        active-high reset to the core
//   cpu_instr/cpu_v0/chk_fail        core observation for run end
//   cycle_cnt/done/status            run result (status held in DONE)
module cpu_run_ctrl #(
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned RST_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ld_valid,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_reset,
    input  logic [31:0]        cpu_instr,
    input  logic [31:0]        cpu_v0,
    input  logic               chk_fail,
    output logic [31:0]        cycle_cnt,
    output logic               done,
    output logic [1:0]         status
);

    localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT - 1);

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_PASS = 2'b01;
    localparam logic [1:0] ST_FAIL = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [IMEM_AW-1:0] addr_q;
    logic [31:0]        cycle_q;
    logic [31:0]        cycle_d;
    logic [HW-1:0]      hold_q;
    logic               done_q;
    logic [1:0]         status_q;
    logic               cpu_reset_q;

    logic xfer;
    logic addr_top;
    logic exit_hit;
    logic tmo_hit;

    assign ld_ready   = (state_q == S_LOAD);
    assign xfer       = ld_valid & ld_ready;
    assign imem_we    = xfer;
    assign imem_addr  = addr_q;
    assign imem_wdata = ld_data;
    assign cpu_reset  = cpu_reset_q;
    assign cycle_cnt  = cycle_q;
    assign done       = done_q;
    assign status     = status_q;

    assign addr_top = &addr_q;
    assign exit_hit = (cpu_instr == 32'h0000_000c) && (cpu_v0 == 32'h0000_000a);
    // cycle_q still holds the pre-increment count, so TIMEOUT-1 here means
    // the terminating cycle is the TIMEOUT-th one.
    assign tmo_hit  = (cycle_q == TO_LAST);
    assign cycle_d  = (&cycle_q) ? cycle_q : cycle_q + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cycle_q     <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            status_q    <= ST_NONE;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_LOAD;
                        addr_q   <= '0;
                        cycle_q  <= '0;
                        status_q <= ST_NONE;
                        done_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        if (ld_last) begin
                            state_q <= S_HOLD;
                            hold_q  <= '0;
                        end else if (addr_top) begin
                            // image larger than imem
                            state_q  <= S_DONE;
                            status_q <= ST_FAIL;
                            done_q   <= 1'b1;
                        end
                        // address sticks at the top instead of wrapping
                        if (!addr_top) begin
                            addr_q <= addr_q + IMEM_AW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_q <= cycle_d;
                    if (chk_fail || exit_hit || tmo_hit) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        if (chk_fail) begin
                            status_q <= ST_FAIL;
                        end else if (exit_hit) begin
                            status_q <= ST_PASS;
                        end else begin
                            status_q <= ST_TMO;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cpu_reset_q <= 1'b1;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
